// File: rtl/pc_redirect_ctrl.sv
// ============================================================================
// Module  : pc_redirect_ctrl
// Purpose : Fetch PC sequencer with branch/jump redirect, stall-pending
//           capture and a two-cycle pipeline flush per applied redirect.
//           Optional macro JUMP_ALIGN_CHECK_EN rejects non-word-aligned targets.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module pc_redirect_ctrl #(
    parameter logic [`ADDR_WIDTH-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   jump_enable_i,
    input  logic [`ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                   hold_i,
    output logic [`ADDR_WIDTH-1:0] pc_o,
    output logic                   flush_o,
    output logic                   inst_valid_o,
    output logic [31:0]            redirect_cnt_o,
    output logic                   misalign_o
);

    localparam int unsigned                AW      = `ADDR_WIDTH;
    localparam logic [`ADDR_WIDTH-1:0]     PC_STEP = AW'(4);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           pc_q, pc_d;
    logic [AW-1:0]           pend_q, pend_d;
    logic                    flush_q, flush_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    mis_q, mis_d;
    logic                    w_bad_target;

`ifdef JUMP_ALIGN_CHECK_EN
    assign w_bad_target = (jump_addr_i[1:0] != 2'b00);
`else
    assign w_bad_target = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        flush_d = 1'b0;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (jump_enable_i && !w_bad_target) begin
                    if (!hold_i) begin
                        pc_d    = jump_addr_i;
                        flush_d = 1'b1;
                        cnt_d   = cnt_q + 32'd1;
                        state_d = ST_FLUSH;
                    end else begin
                        pend_d  = jump_addr_i;
                        state_d = ST_PEND;
                    end
                end else begin
                    // A rejected target behaves like a plain sequential cycle.
                    mis_d = jump_enable_i & w_bad_target;
                    if (!hold_i) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            ST_PEND: begin
                if (!hold_i) begin
                    pc_d    = pend_q;
                    flush_d = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                if (!hold_i) begin
                    pc_d = pc_q + PC_STEP;
                end
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_ADDR;
            pend_q  <= '0;
            flush_q <= 1'b0;
            cnt_q   <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pc_o           = pc_q;
    assign flush_o        = flush_q;
    assign redirect_cnt_o = cnt_q;
    assign misalign_o     = mis_q;
    assign inst_valid_o   = ~flush_q & ~hold_i & rst_i;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// Directed, table-driven bench for pc_redirect_ctrl (default and
// JUMP_ALIGN_CHECK_EN builds).
`default_nettype none

module tb_pc_redirect_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        jump_enable_i;
    logic [31:0] jump_addr_i;
    logic        hold_i;
    logic [31:0] pc_o;
    logic        flush_o;
    logic        inst_valid_o;
    logic [31:0] redirect_cnt_o;
    logic        misalign_o;

    pc_redirect_ctrl #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .jump_enable_i  (jump_enable_i),
        .jump_addr_i    (jump_addr_i),
        .hold_i         (hold_i),
        .pc_o           (pc_o),
        .flush_o        (flush_o),
        .inst_valid_o   (inst_valid_o),
        .redirect_cnt_o (redirect_cnt_o),
        .misalign_o     (misalign_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        jen;
        logic [31:0] jaddr;
        logic        hold;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic [31:0] exp_cnt;
        logic        exp_mis;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vec [NVEC];

    int checks   = 0;
    int failures = 0;
    logic seen300 = 1'b0;
    logic seen500 = 1'b0;

    always @(negedge clk_i) begin
        if (pc_o == 32'h0000_0300) seen300 <= 1'b1;
        if (pc_o == 32'h0000_0500) seen500 <= 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] last_pc;

        // {jen, jaddr, hold, exp_pc, exp_flush, exp_cnt, exp_mis}
        vec[0]  = '{1'b0, 32'h0,        1'b0, 32'h4,        1'b0, 32'd0, 1'b0};
        vec[1]  = '{1'b0, 32'h0,        1'b0, 32'h8,        1'b0, 32'd0, 1'b0};
        vec[2]  = '{1'b0, 32'h0,        1'b0, 32'hC,        1'b0, 32'd0, 1'b0};
        vec[3]  = '{1'b0, 32'h0,        1'b0, 32'h10,       1'b0, 32'd0, 1'b0};
        vec[4]  = '{1'b1, 32'h100,      1'b0, 32'h100,      1'b1, 32'd1, 1'b0};
        vec[5]  = '{1'b0, 32'h0,        1'b0, 32'h104,      1'b1, 32'd1, 1'b0};
        vec[6]  = '{1'b0, 32'h0,        1'b0, 32'h108,      1'b0, 32'd1, 1'b0};
        vec[7]  = '{1'b1, 32'h200,      1'b1, 32'h108,      1'b0, 32'd1, 1'b0};
        vec[8]  = '{1'b1, 32'h300,      1'b1, 32'h108,      1'b0, 32'd1, 1'b0};
        vec[9]  = '{1'b0, 32'h0,        1'b1, 32'h108,      1'b0, 32'd1, 1'b0};
        vec[10] = '{1'b0, 32'h0,        1'b0, 32'h200,      1'b1, 32'd2, 1'b0};
        vec[11] = '{1'b0, 32'h0,        1'b0, 32'h204,      1'b1, 32'd2, 1'b0};
        vec[12] = '{1'b0, 32'h0,        1'b0, 32'h208,      1'b0, 32'd2, 1'b0};
        vec[13] = '{1'b1, 32'h40,       1'b0, 32'h40,       1'b1, 32'd3, 1'b0};
        vec[14] = '{1'b1, 32'h80,       1'b0, 32'h44,       1'b1, 32'd3, 1'b0};
        vec[15] = '{1'b0, 32'h0,        1'b0, 32'h48,       1'b0, 32'd3, 1'b0};
        vec[16] = '{1'b0, 32'h0,        1'b1, 32'h48,       1'b0, 32'd3, 1'b0};
        vec[17] = '{1'b1, 32'h1000,     1'b0, 32'h1000,     1'b1, 32'd4, 1'b0};
        vec[18] = '{1'b0, 32'h0,        1'b1, 32'h1000,     1'b1, 32'd4, 1'b0};
        vec[19] = '{1'b0, 32'h0,        1'b0, 32'h1004,     1'b0, 32'd4, 1'b0};
        vec[20] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'd5, 1'b0};
        vec[21] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'd5, 1'b0};
        vec[22] = '{1'b0, 32'h0,        1'b0, 32'h4,        1'b0, 32'd5, 1'b0};
`ifdef JUMP_ALIGN_CHECK_EN
        vec[23] = '{1'b1, 32'h102,      1'b0, 32'h8,        1'b0, 32'd5, 1'b1};
        vec[24] = '{1'b0, 32'h0,        1'b0, 32'hC,        1'b0, 32'd5, 1'b0};
        vec[25] = '{1'b0, 32'h0,        1'b0, 32'h10,       1'b0, 32'd5, 1'b0};
`else
        vec[23] = '{1'b1, 32'h102,      1'b0, 32'h102,      1'b1, 32'd6, 1'b0};
        vec[24] = '{1'b0, 32'h0,        1'b0, 32'h106,      1'b1, 32'd6, 1'b0};
        vec[25] = '{1'b0, 32'h0,        1'b0, 32'h10A,      1'b0, 32'd6, 1'b0};
`endif

        rst_i         = 1'b0;
        jump_enable_i = 1'b0;
        jump_addr_i   = 32'h0;
        hold_i        = 1'b0;
        tick();
        tick();
        check("rst_pc",    pc_o,                 32'h0);
        check("rst_flush", {31'd0, flush_o},     32'd0);
        check("rst_cnt",   redirect_cnt_o,       32'd0);
        check("rst_mis",   {31'd0, misalign_o},  32'd0);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        check("rel_pc0",   pc_o,                 32'h0);
        check("rel_valid", {31'd0, inst_valid_o}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            jump_enable_i = vec[i].jen;
            jump_addr_i   = vec[i].jaddr;
            hold_i        = vec[i].hold;
            tick();
            check($sformatf("v%0d_pc", i),    pc_o,                vec[i].exp_pc);
            check($sformatf("v%0d_flush", i), {31'd0, flush_o},    {31'd0, vec[i].exp_flush});
            check($sformatf("v%0d_cnt", i),   redirect_cnt_o,      vec[i].exp_cnt);
            check($sformatf("v%0d_mis", i),   {31'd0, misalign_o}, {31'd0, vec[i].exp_mis});
            check($sformatf("v%0d_valid", i), {31'd0, inst_valid_o},
                  {31'd0, ~vec[i].exp_flush & ~vec[i].hold});
        end
        last_pc = vec[NVEC-1].exp_pc;

        // Reset while a redirect is pending: target must be discarded.
        jump_enable_i = 1'b1;
        jump_addr_i   = 32'h500;
        hold_i        = 1'b1;
        tick();
        check("pend_pc", pc_o, last_pc);
        jump_enable_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        check("pend_arst_pc",    pc_o,                  32'h0);
        check("pend_arst_cnt",   redirect_cnt_o,        32'd0);
        check("pend_arst_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        rst_i  = 1'b1;
        hold_i = 1'b0;
        tick();
        check("pend_rel_pc4",   pc_o,             32'h4);
        check("pend_rel_flush", {31'd0, flush_o}, 32'd0);
        check("pend_rel_cnt",   redirect_cnt_o,   32'd0);
        tick();
        check("pend_rel_pc8",   pc_o,             32'h8);
        check("pend_rel_flush2", {31'd0, flush_o}, 32'd0);

        // Reset during the FLUSH cycle, then released with hold asserted.
        jump_enable_i = 1'b1;
        jump_addr_i   = 32'h40;
        tick();
        check("fl_pc",    pc_o,             32'h40);
        check("fl_flush", {31'd0, flush_o}, 32'd1);
        jump_enable_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        check("fl_arst_flush", {31'd0, flush_o}, 32'd0);
        check("fl_arst_pc",    pc_o,             32'h0);
        tick();
        rst_i  = 1'b1;
        hold_i = 1'b1;
        #1;
        check("fl_hold_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check("fl_hold_pc", pc_o, 32'h0);
        hold_i = 1'b0;
        tick();
        check("fl_run_pc",    pc_o,             32'h4);
        check("fl_run_flush", {31'd0, flush_o}, 32'd0);
        check("fl_run_cnt",   redirect_cnt_o,   32'd0);

        check("never_300", {31'd0, seen300}, 32'd0);
        check("never_500", {31'd0, seen500}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter: RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: jump_enable_i  input  1  redirect request from the branch/jump execute unit.
REQ-005 SHALL have port: jump_addr_i  input  `ADDR_WIDTH  redirect target from the branch/jump execute unit.
REQ-006 SHALL have port: hold_i  input  1  pipeline stall; freezes the PC.
REQ-007 SHALL have port: pc_o  output  `ADDR_WIDTH  instruction fetch address (registered).
REQ-008 SHALL have port: flush_o  output  1  squash the IF/ID and ID/EX stages (registered).
REQ-009 SHALL have port: inst_valid_o  output  1  the fetched instruction at pc_o is architecturally valid.
REQ-010 SHALL have port: redirect_cnt_o  output  32  count of applied redirects.
REQ-011 SHALL have port: misalign_o  output  1  misaligned-target pulse (see Configuration).

Function
REQ-012 SHALL implement an FSM with states RUN, PEND and FLUSH.
REQ-013 In RUN with jump_enable_i=1 and hold_i=0: pc_o <= jump_addr_i, next state FLUSH, flush_o <= 1, redirect_cnt_o += 1.
REQ-014 In RUN with jump_enable_i=1 and hold_i=1: latch jump_addr_i into a pending register, hold pc_o, next state PEND.
REQ-015 In RUN with jump_enable_i=0: hold_i=1 holds pc_o; hold_i=0 sets pc_o <= pc_o + 4.
REQ-016 In PEND: jump_enable_i SHALL be ignored and the first latched target SHALL be kept.
REQ-017 In PEND with hold_i=1: pc_o is held and the state stays PEND.
REQ-018 In PEND with hold_i=0: pc_o <= pending target, flush_o <= 1, counter += 1, next state FLUSH.
REQ-019 FLUSH SHALL last exactly one cycle: jump_enable_i ignored (squashed instruction), flush_o <= 1, then RUN.
REQ-020 In FLUSH: pc_o <= pc_o + 4 if hold_i=0, else held; the state returns to RUN regardless of hold_i.
REQ-021 Net effect: flush_o is high for exactly 2 consecutive cycles per applied redirect (redirect edge plus the FLUSH cycle).
REQ-022 inst_valid_o SHALL equal ~flush_o & ~hold_i & rst_i, combinationally.
REQ-023 PC arithmetic SHALL be modulo 2^ADDR_WIDTH: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-024 redirect_cnt_o SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-025 Jump latency: the target appears on pc_o one cycle after the accepting edge; no combinational path from jump_addr_i to pc_o.

Reset
REQ-026 While rst_i=0 the block SHALL hold: pc_o=RESET_ADDR, state RUN, flush_o=0, redirect_cnt_o=0, misalign_o=0, pending register=0.
REQ-027 Reset asserted mid-PEND or mid-FLUSH SHALL discard the pending target immediately, with no redirect after release.
REQ-028 On the first edge after release, pc_o SHALL advance to RESET_ADDR+4 unless hold_i or jump_enable_i is asserted.

Configuration
REQ-029 Macro JUMP_ALIGN_CHECK_EN SHALL control the target alignment check.
REQ-030 With JUMP_ALIGN_CHECK_EN defined: in RUN, jump_enable_i=1 with jump_addr_i[1:0]!=0 SHALL be rejected; misalign_o pulses 1 cycle, there is no redirect, counter is unchanged, and the PC follows the REQ-015 rules.
REQ-031 Without JUMP_ALIGN_CHECK_EN: misalign_o SHALL be tied to 0 and any target is accepted verbatim.

Verification
REQ-032 Reset release, no stimulus, 4 cycles -> pc_o 0x0, 0x4, 0x8, 0xC, 0x10; flush_o=0.
REQ-033 At pc_o=0x10, jump_enable_i=1, jump_addr_i=0x100 for 1 cycle -> next pc_o=0x100, flush_o=1 for 2 cycles, then pc_o=0x104, redirect_cnt_o=1.
REQ-034 hold_i=1 with a jump to 0x200, then a jump to 0x300 while held, release after 3 cycles -> pc_o=0x200, 0x300 never loaded, redirect_cnt_o increments once.
REQ-035 Jump to 0x40 immediately followed by jump_enable_i=1 with target 0x80 during FLUSH -> second request ignored; pc_o=0x40 then 0x44.
REQ-036 rst_i=0 asserted in PEND (target 0x500), then released -> pc_o=RESET_ADDR, redirect_cnt_o=0, 0x500 never appears.
REQ-037 With JUMP_ALIGN_CHECK_EN, jump to 0x102 at pc_o=0x20 -> misalign_o=1 for 1 cycle, pc_o=0x24, flush_o=0; without the macro -> pc_o=0x102.
